// File: rtl/pipe_stage.sv
// Two-entry skid pipeline stage: registered in_ready, 1-cycle latency, synchronous flush.
// Optional PIPE_STAGE_PERF_EN adds saturating stall/flush counters.
module pipe_stage #(
  parameter int               DATA_W  = 32,
  parameter int               PC_W    = 32,
  parameter logic [DATA_W-1:0] NOP_VAL = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              R,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [PC_W-1:0]   out_pc
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [PC_W-1:0]   pc;
  } word_t;

  localparam word_t NOP_W = word_t'({NOP_VAL, {PC_W{1'b0}}});

  state_t state_q, state_d;
  word_t  main_q, main_d, skid_q, skid_d, in_w;
  logic   accept, consume;

  assign in_w    = word_t'({in_data, in_pc});
  assign accept  = in_valid & in_ready;
  assign consume = out_valid & out_ready;

  always_ff @(posedge clk or posedge R) begin
    if (R) state_q <= EMPTY;
    else   state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) state_d = EMPTY;
    else begin
      unique case (state_q)
        EMPTY:   if (accept) state_d = ONE;
        ONE:     if (accept && !consume) state_d = TWO;
                 else if (consume && !accept) state_d = EMPTY;
        TWO:     if (consume) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  // in_ready decodes registered state only, so out_ready never reaches it
  always_comb begin
    in_ready  = (state_q != TWO);
    out_valid = (state_q != EMPTY);
    out_data  = main_q.data;
    out_pc    = main_q.pc;
  end

  // main is parked at NOP whenever the stage goes empty, so outputs need no muxing
  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (flush) begin
      main_d = NOP_W;
      skid_d = NOP_W;
    end else begin
      unique case (state_q)
        EMPTY: if (accept) main_d = in_w;
        ONE: begin
          if (accept && consume)  main_d = in_w;
          else if (accept)        skid_d = in_w;
          else if (consume)       main_d = NOP_W;
        end
        TWO: if (consume) begin
          main_d = skid_q;
          skid_d = NOP_W;
        end
        default: begin
          main_d = NOP_W;
          skid_d = NOP_W;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      main_q <= NOP_W;
      skid_q <= NOP_W;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (flush && flush_cnt != 16'hFFFF)                   flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage.sv
// Bench for pipe_stage: directed scenarios plus random traffic against a queue-based model.
// Counter checks are active when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage;
  logic        clk = 1'b0;
  logic        R;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_data, in_pc, out_data, out_pc;

  logic        b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
  logic [15:0] b_in_data, b_out_data;
  logic [7:0]  b_in_pc, b_out_pc;
`ifdef PIPE_STAGE_PERF_EN
  logic [15:0] stall_cnt, flush_cnt, b_stall_cnt, b_flush_cnt;
`endif

  always #5 clk = ~clk;

  pipe_stage dut (
    .clk(clk), .R(R), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_pc(out_pc)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  pipe_stage #(.DATA_W(16), .PC_W(8), .NOP_VAL(16'hBEEF)) dut_b (
    .clk(clk), .R(R), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_pc(b_in_pc), .flush(b_flush), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_pc(b_out_pc)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
`endif
  );

  // Reference: the stage is a FIFO of capacity two; head is presented, empty shows 0/0.
  typedef struct { logic [31:0] d; logic [31:0] pc; } w_t;
  w_t mq[$];
  int m_stall, m_flush;
  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(mq.size() > 0));
    chk({tag, ".in_ready"},  64'(in_ready),  64'(mq.size() < 2));
    chk({tag, ".out_data"},  64'(out_data),  (mq.size() > 0) ? 64'(mq[0].d)  : 64'd0);
    chk({tag, ".out_pc"},    64'(out_pc),    (mq.size() > 0) ? 64'(mq[0].pc) : 64'd0);
`ifdef PIPE_STAGE_PERF_EN
    chk({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(m_stall));
    chk({tag, ".flush_cnt"}, 64'(flush_cnt), 64'(m_flush));
`endif
  endtask

  // One clock: model decides accept/consume from pre-edge occupancy, then checks 1ns after.
  task automatic step(input string tag, input bit do_chk);
    bit acc, con;
    w_t w;
    acc = in_valid && (mq.size() < 2);
    con = (mq.size() > 0) && out_ready;
    w.d = in_data;
    w.pc = in_pc;
    if (mq.size() > 0 && !out_ready && m_stall < 32'hFFFF) m_stall++;
    if (flush && m_flush < 32'hFFFF) m_flush++;
    @(posedge clk);
    if (flush) mq.delete();
    else begin
      if (con) void'(mq.pop_front());
      if (acc) mq.push_back(w);
    end
    #1;
    if (do_chk) check_all(tag);
  endtask

  // Asynchronous pulse between edges; checked before the next edge arrives.
  task automatic pulse_reset(input string tag);
    R = 1'b1;
    #1;
    mq.delete();
    m_stall = 0;
    m_flush = 0;
    check_all(tag);
    R = 1'b0;
  endtask

  initial begin
    R = 1'b0; in_valid = 0; out_ready = 0; flush = 0; in_data = '0; in_pc = '0;
    b_in_valid = 0; b_out_ready = 1; b_flush = 0; b_in_data = '0; b_in_pc = '0;
    m_stall = 0; m_flush = 0;
    #1;
    pulse_reset("reset");

    // back-to-back streaming
    in_valid = 1; out_ready = 1; in_data = 32'hE3A01005; in_pc = 32'h100;
    step("stream0", 1);
    chk("stream0.word", 64'(out_data), 64'hE3A01005);
    in_data = 32'hE2811001; in_pc = 32'h104;
    step("stream1", 1);
    chk("stream1.word", 64'(out_data), 64'hE2811001);
    chk("stream1.ready", 64'(in_ready), 64'd1);
    in_valid = 0;
    step("stream_drain", 1);

    // backpressure: A, B held, C withheld, then A, B, C in order
    out_ready = 0; in_valid = 1; in_data = 32'hAAAA0001; in_pc = 32'h200;
    step("bp_a", 1);
    in_data = 32'hBBBB0002; in_pc = 32'h204;
    step("bp_b", 1);
    chk("bp.ready_low", 64'(in_ready), 64'd0);
    chk("bp.head_a", 64'(out_data), 64'hAAAA0001);
    in_data = 32'hCCCC0003; in_pc = 32'h208;
    step("bp_c_held", 1);
    chk("bp.still_a", 64'(out_data), 64'hAAAA0001);
    out_ready = 1;
    step("bp_out_a", 1);
    chk("bp.now_b", 64'(out_data), 64'hBBBB0002);
    step("bp_out_b", 1);
    chk("bp.now_c", 64'(out_data), 64'hCCCC0003);
    in_valid = 0;
    step("bp_out_c", 1);
    chk("bp.empty", 64'(out_valid), 64'd0);

    // flush in TWO with a simultaneous offer
    out_ready = 0; in_valid = 1; in_data = 32'h11111111;
    step("fl_fill0", 1);
    in_data = 32'h22222222;
    step("fl_fill1", 1);
    in_ready_wait: chk("fl.two", 64'(in_ready), 64'd0);
    flush = 1; in_data = 32'h33333333;
    step("fl_edge", 1);
    chk("fl.valid", 64'(out_valid), 64'd0);
    chk("fl.data", 64'(out_data), 64'h0);
    chk("fl.ready", 64'(in_ready), 64'd1);
    flush = 0; in_valid = 0; out_ready = 1;
    step("fl_after", 1);

    // async reset while in ONE
    out_ready = 0; in_valid = 1; in_data = 32'h5A5A5A5A; in_pc = 32'h300;
    step("rst_one", 1);
    in_valid = 0;
    #2;
    pulse_reset("rst_mid");
    chk("rst_mid.valid", 64'(out_valid), 64'd0);
    in_valid = 1; in_data = 32'h66666666;
    step("rst_first_acc", 1);
    in_valid = 0; out_ready = 1;
    step("rst_drain", 1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_data   = $urandom;
      in_pc     = $urandom;
      step("rand", 1);
    end
    in_valid = 0; flush = 0; out_ready = 1;
    step("rand_drain0", 1);
    step("rand_drain1", 1);

    // narrow instance with non-zero bubble value
    chk("narrow.nop", 64'(b_out_data), 64'hBEEF);
    chk("narrow.idle", 64'(b_out_valid), 64'd0);
    b_in_valid = 1; b_out_ready = 0; b_in_data = 16'h1234; b_in_pc = 8'h40;
    step("narrow_load", 1);
    chk("narrow.valid", 64'(b_out_valid), 64'd1);
    chk("narrow.data", 64'(b_out_data), 64'h1234);
    chk("narrow.pc", 64'(b_out_pc), 64'h40);
    b_in_valid = 0; b_out_ready = 1;
    step("narrow_out", 1);
    chk("narrow.empty", 64'(b_out_valid), 64'd0);
    chk("narrow.nop2", 64'(b_out_data), 64'hBEEF);
    chk("narrow.pc0", 64'(b_out_pc), 64'h0);

`ifdef PIPE_STAGE_PERF_EN
    // long stall must saturate, not wrap
    #2;
    pulse_reset("perf_rst");
    in_valid = 1; out_ready = 0; in_data = 32'h77777777;
    step("perf_load", 1);
    in_valid = 0;
    for (int i = 0; i < 70000; i++) step("perf_hold", 0);
    check_all("perf_end");
    chk("perf.sat", 64'(stall_cnt), 64'hFFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
